calc_entry_sequencer: RTL

- Front-end controller for the calculator datapath (adder/subtractor/multiplier behind a 4-way result mux).
- Accepts one-cycle keypad key events and accumulates decimal digits into two 16-bit operands.
- Drives operands and a one-hot operation code into the combinational calculation unit, captures its 32-bit result and sign, and sequences the display.
- Sits between the keypad decoder and the display driver.

---
 rtl/calc_pkg.sv | 32 +++
 rtl/decimal_digit_accumulator.sv | 28 ++
 rtl/calc_entry_sequencer.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/calc_pkg.sv
// Shared definitions for the calculator entry front-end: key codes, one-hot
// operation encodings and the sequencer state enum.
package calc_pkg;

    localparam logic [3:0] KEY_ADD = 4'd10;
    localparam logic [3:0] KEY_SUB = 4'd11;
    localparam logic [3:0] KEY_MUL = 4'd12;
    localparam logic [3:0] KEY_EQ  = 4'd13;
    localparam logic [3:0] KEY_CLR = 4'd14;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_ADD  = 3'b001;
    localparam logic [2:0] OP_SUB  = 3'b010;
    localparam logic [2:0] OP_MUL  = 3'b100;

    typedef enum logic [1:0] {
        ST_ENTER_A = 2'd0,
        ST_ENTER_B = 2'd1,
        ST_CALC    = 2'd2,
        ST_SHOW    = 2'd3
    } calc_state_e;

    function automatic logic [2:0] key_to_op(input logic [3:0] key);
        case (key)
            KEY_ADD: return OP_ADD;
            KEY_SUB: return OP_SUB;
            KEY_MUL: return OP_MUL;
            default: return OP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/decimal_digit_accumulator.sv
// Combinational decimal digit append: acc*10 + digit with digit-count and
// magnitude limits. The candidate is kept 20 bits wide so overflow is visible.
module decimal_digit_accumulator #(
    parameter int MAX_DIGITS  = 5,
    parameter int MAX_OPERAND = 65535
) (
    input  logic [15:0] i_acc,
    input  logic [3:0]  i_digit,
    input  logic [2:0]  i_count,
    output logic [15:0] o_next_acc,
    output logic [2:0]  o_next_count,
    output logic        o_overflow
);

    logic [19:0] w_acc_wide;
    logic [19:0] w_candidate;
    logic        w_leading_zero;

    assign w_acc_wide     = {4'b0, i_acc};
    assign w_candidate    = (w_acc_wide << 3) + (w_acc_wide << 1) + {16'b0, i_digit};
    assign w_leading_zero = (i_acc == 16'd0) && (i_digit == 4'd0);

    assign o_overflow   = (i_count == 3'(MAX_DIGITS)) || (w_candidate > 20'(MAX_OPERAND));
    assign o_next_acc   = o_overflow ? i_acc : w_candidate[15:0];
    // Leading zeros leave the count alone so "007" still allows a full operand.
    assign o_next_count = (o_overflow || w_leading_zero) ? i_count : i_count + 3'd1;

endmodule

// File: rtl/calc_entry_sequencer.sv
// Keypad-driven operand entry and result sequencing in front of the
// combinational add/sub/mul unit; latches the 32-bit result for display.
module calc_entry_sequencer
    import calc_pkg::*;
#(
    parameter int MAX_DIGITS  = 5,
    parameter int MAX_OPERAND = 65535
) (
    input  logic        IN_clk,
    input  logic        IN_rst_n,
    input  logic        IN_key_valid,
    input  logic [3:0]  IN_key_code,
    input  logic [31:0] IN_answer,
    input  logic        IN_is_negative,
    output logic [15:0] OUT_num1,
    output logic [15:0] OUT_num2,
    output logic [2:0]  OUT_operation_code,
    output logic [31:0] OUT_display,
    output logic        OUT_display_negative,
    output logic        OUT_result_valid,
    output logic        OUT_error
);

    calc_state_e r_state, w_state_nxt;
    logic [15:0] r_num1, w_num1_nxt;
    logic [15:0] r_num2, w_num2_nxt;
    logic [2:0]  r_count, w_count_nxt;
    logic [2:0]  r_op, w_op_nxt;
    logic [31:0] r_result, w_result_nxt;
    logic        r_result_neg, w_result_neg_nxt;
    logic        r_result_valid, w_result_valid_nxt;
    logic        r_error, w_error_nxt;

    logic        w_is_digit;
    logic        w_is_op;
    logic [15:0] w_acc_in;
    logic [15:0] w_acc_next;
    logic [2:0]  w_acc_count_next;
    logic        w_acc_overflow;
    logic        w_chain_ok;

    assign w_is_digit = (IN_key_code <= 4'd9);
    assign w_is_op    = (IN_key_code == KEY_ADD) || (IN_key_code == KEY_SUB) ||
                        (IN_key_code == KEY_MUL);
    assign w_acc_in   = (r_state == ST_ENTER_B) ? r_num2 : r_num1;
    assign w_chain_ok = !r_result_neg && (r_result <= 32'(MAX_OPERAND));

    decimal_digit_accumulator #(
        .MAX_DIGITS  (MAX_DIGITS),
        .MAX_OPERAND (MAX_OPERAND)
    ) u_accum (
        .i_acc        (w_acc_in),
        .i_digit      (IN_key_code),
        .i_count      (r_count),
        .o_next_acc   (w_acc_next),
        .o_next_count (w_acc_count_next),
        .o_overflow   (w_acc_overflow)
    );

    always_ff @(posedge IN_clk or negedge IN_rst_n) begin
        if (!IN_rst_n) begin
            r_state        <= ST_ENTER_A;
            r_num1         <= 16'd0;
            r_num2         <= 16'd0;
            r_count        <= 3'd0;
            r_op           <= OP_NONE;
            r_result       <= 32'd0;
            r_result_neg   <= 1'b0;
            r_result_valid <= 1'b0;
            r_error        <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_num1         <= w_num1_nxt;
            r_num2         <= w_num2_nxt;
            r_count        <= w_count_nxt;
            r_op           <= w_op_nxt;
            r_result       <= w_result_nxt;
            r_result_neg   <= w_result_neg_nxt;
            r_result_valid <= w_result_valid_nxt;
            r_error        <= w_error_nxt;
        end
    end

    always_comb begin
        w_state_nxt        = r_state;
        w_num1_nxt         = r_num1;
        w_num2_nxt         = r_num2;
        w_count_nxt        = r_count;
        w_op_nxt           = r_op;
        w_result_nxt       = r_result;
        w_result_neg_nxt   = r_result_neg;
        w_result_valid_nxt = 1'b0;
        w_error_nxt        = r_error;

        if (IN_key_valid && (IN_key_code == KEY_CLR)) begin
            w_state_nxt      = ST_ENTER_A;
            w_num1_nxt       = 16'd0;
            w_num2_nxt       = 16'd0;
            w_count_nxt      = 3'd0;
            w_op_nxt         = OP_NONE;
            w_result_nxt     = 32'd0;
            w_result_neg_nxt = 1'b0;
            w_error_nxt      = 1'b0;
        end else begin
            case (r_state)
                ST_ENTER_A: begin
                    if (IN_key_valid && w_is_digit) begin
                        if (w_acc_overflow) begin
                            w_error_nxt = 1'b1;
                        end else begin
                            w_num1_nxt  = w_acc_next;
                            w_count_nxt = w_acc_count_next;
                        end
                    end else if (IN_key_valid && w_is_op) begin
                        w_op_nxt    = key_to_op(IN_key_code);
                        w_num2_nxt  = 16'd0;
                        w_count_nxt = 3'd0;
                        w_state_nxt = ST_ENTER_B;
                    end
                end
                ST_ENTER_B: begin
                    if (IN_key_valid && w_is_digit) begin
                        if (w_acc_overflow) begin
                            w_error_nxt = 1'b1;
                        end else begin
                            w_num2_nxt  = w_acc_next;
                            w_count_nxt = w_acc_count_next;
                        end
                    end else if (IN_key_valid && w_is_op && (r_count == 3'd0)) begin
                        w_op_nxt = key_to_op(IN_key_code);
                    end else if (IN_key_valid && (IN_key_code == KEY_EQ)) begin
                        w_state_nxt = ST_CALC;
                    end
                end
                ST_CALC: begin
                    w_result_nxt       = IN_answer;
                    w_result_neg_nxt   = IN_is_negative;
                    w_result_valid_nxt = 1'b1;
                    w_state_nxt        = ST_SHOW;
                end
                ST_SHOW: begin
                    if (IN_key_valid && w_is_digit) begin
                        w_num1_nxt  = {12'b0, IN_key_code};
                        w_count_nxt = {2'b0, (IN_key_code != 4'd0)};
                        w_num2_nxt  = 16'd0;
                        w_op_nxt    = OP_NONE;
                        w_state_nxt = ST_ENTER_A;
                    end else if (IN_key_valid && w_is_op) begin
                        // Chaining reuses the result as operand A only if it fits.
                        if (w_chain_ok) begin
                            w_num1_nxt  = r_result[15:0];
                            w_num2_nxt  = 16'd0;
                            w_count_nxt = 3'd0;
                            w_op_nxt    = key_to_op(IN_key_code);
                            w_state_nxt = ST_ENTER_B;
                        end else begin
                            w_error_nxt = 1'b1;
                        end
                    end
                end
                default: w_state_nxt = ST_ENTER_A;
            endcase
        end
    end

    always_comb begin
        OUT_display = {16'b0, r_num1};
        case (r_state)
            ST_ENTER_B, ST_CALC: OUT_display = {16'b0, r_num2};
            ST_SHOW:             OUT_display = r_result;
            default:             OUT_display = {16'b0, r_num1};
        endcase
    end

    assign OUT_num1             = r_num1;
    assign OUT_num2             = r_num2;
    assign OUT_operation_code   = r_op;
    assign OUT_display_negative = (r_state == ST_SHOW) && r_result_neg;
    assign OUT_result_valid     = r_result_valid;
    assign OUT_error            = r_error;

endmodule
